// File: rtl/bf8b_pkg.sv
// Shared definitions for the bf8b 8-bit core: opcodes, register-file geometry
// and the execute-stage state encoding.
package bf8b_pkg;

    localparam int REG_W   = 8;
    localparam int REG_CNT = 16;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LOD = 2'b01;
    localparam logic [1:0] OP_STR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_DONE
    } state_t;

endpackage

// File: rtl/execute_regfile_mux.sv
// regfile_mux: combinational byte select of one register out of the flattened
// register-file snapshot exported by writeback.
module regfile_mux
    import bf8b_pkg::*;
(
    input  logic [REG_W*REG_CNT-1:0] regs_flat,
    input  logic [3:0]               sel,
    output logic [REG_W-1:0]         data
);

    logic [REG_W-1:0] regs_arr [REG_CNT];

    generate
        for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_unpack
            assign regs_arr[gi] = regs_flat[gi*REG_W +: REG_W];
        end
    endgenerate

    assign data = regs_arr[sel];

endmodule

// File: rtl/execute.sv
// Execute stage of the bf8b core: ADD, or a LOD/STR memory access with timeout,
// then a held-enable handshake to writeback. Optional carry output: CARRY_FLAG_EN.
module execute
    import bf8b_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               op,
    input  logic [3:0]               rd_addr,
    input  logic [3:0]               rs_addr,
    input  logic [7:0]               imm,
    input  logic [REG_W*REG_CNT-1:0] regs_flat,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [7:0]               mem_addr,
    output logic [7:0]               mem_wdata,
    input  logic                     mem_ack,
    input  logic [7:0]               mem_rdata,
    output logic                     wb_en,
    output logic [1:0]               wb_op,
    output logic [3:0]               wb_reg_addr,
    output logic [7:0]               wb_val,
    input  logic                     wb_ready,
    output logic                     done,
    output logic                     err
`ifdef CARRY_FLAG_EN
    ,
    output logic                     carry
`endif
);

    // Last counter value that may still see an ack before the abort.
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg;
    logic [1:0]       op_reg;
    logic [3:0]       rd_reg;
    logic [3:0]       rs_reg;
    logic [7:0]       imm_reg;
    logic [7:0]       cnt_reg;
    logic [REG_W-1:0] rd_val;
    logic [REG_W-1:0] rs_val;
    logic [REG_W:0]   sum;

    regfile_mux u_rd_mux (
        .regs_flat (regs_flat),
        .sel       (rd_reg),
        .data      (rd_val)
    );

    regfile_mux u_rs_mux (
        .regs_flat (regs_flat),
        .sel       (rs_reg),
        .data      (rs_val)
    );

    assign sum = {1'b0, rd_val} + {1'b0, rs_val};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_NOP;
            rd_reg      <= '0;
            rs_reg      <= '0;
            imm_reg     <= '0;
            cnt_reg     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            wb_en       <= 1'b0;
            wb_op       <= OP_NOP;
            wb_reg_addr <= '0;
            wb_val      <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (en) begin
                        op_reg    <= op;
                        rd_reg    <= rd_addr;
                        rs_reg    <= rs_addr;
                        imm_reg   <= imm;
                        state_reg <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (op_reg == OP_LOD || op_reg == OP_STR) begin
                        mem_req   <= 1'b1;
                        mem_addr  <= imm_reg;
                        mem_we    <= (op_reg == OP_STR);
                        mem_wdata <= (op_reg == OP_STR) ? rd_val : '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_MEM;
                    end else begin
                        wb_val      <= (op_reg == OP_ADD) ? sum[REG_W-1:0] : '0;
                        wb_en       <= 1'b1;
                        wb_op       <= op_reg;
                        wb_reg_addr <= rd_reg;
                        state_reg   <= ST_WB;
                    end
                end
                ST_MEM: begin
                    // An ack arriving on the final allowed cycle still completes.
                    if (mem_ack) begin
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        wb_val      <= (op_reg == OP_LOD) ? mem_rdata : '0;
                        wb_en       <= 1'b1;
                        wb_op       <= op_reg;
                        wb_reg_addr <= rd_reg;
                        state_reg   <= ST_WB;
                    end else if (cnt_reg == CNT_LAST) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        err       <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wb_en     <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef CARRY_FLAG_EN
    logic carry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (state_reg == ST_EXEC && op_reg == OP_ADD) begin
            carry_reg <= sum[REG_W];
        end
    end

    assign carry = carry_reg;
`else
    logic unused_carry;
    assign unused_carry = sum[REG_W];
`endif

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: table vectors, random instructions against a
// transaction-level model, and reset / ignored-enable corner sequences.
module tb_execute;
    import bf8b_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   op;
    logic [3:0]   rd_addr;
    logic [3:0]   rs_addr;
    logic [7:0]   imm;
    logic [127:0] regs_flat;
    logic         mem_req;
    logic         mem_we;
    logic [7:0]   mem_addr;
    logic [7:0]   mem_wdata;
    logic         mem_ack;
    logic [7:0]   mem_rdata;
    logic         wb_en;
    logic [1:0]   wb_op;
    logic [3:0]   wb_reg_addr;
    logic [7:0]   wb_val;
    logic         wb_ready;
    logic         done;
    logic         err;
`ifdef CARRY_FLAG_EN
    logic         carry;
`endif

    execute dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .op          (op),
        .rd_addr     (rd_addr),
        .rs_addr     (rs_addr),
        .imm         (imm),
        .regs_flat   (regs_flat),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_en       (wb_en),
        .wb_op       (wb_op),
        .wb_reg_addr (wb_reg_addr),
        .wb_val      (wb_val),
        .wb_ready    (wb_ready),
        .done        (done),
        .err         (err)
`ifdef CARRY_FLAG_EN
        ,
        .carry       (carry)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;
    int exp_carry = 0;

    // Observations gathered by run()
    int r_req_cycles, r_we, r_addr, r_wdata;
    int r_wb_cycles, r_wb_val, r_wb_op, r_wb_addr;
    int r_done_cycle, r_done_cnt, r_err_cycle, r_err_cnt, r_unstable;

    typedef struct {
        logic [1:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [7:0] imm;
        logic [7:0] rdv;
        logic [7:0] rsv;
        int         ack;
        logic [7:0] rdata;
        int         extra;
        int         exp_val;
        int         exp_done;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Issue one instruction and act as memory and writeback for 30 cycles.
    task automatic run(input logic [1:0] t_op, input logic [3:0] t_rd, input logic [3:0] t_rs,
                       input logic [7:0] t_imm, input logic [7:0] t_rdv, input logic [7:0] t_rsv,
                       input int ack_cyc, input logic [7:0] t_rdata, input int extra,
                       input bit en_in_wb);
        int  mem_cnt = 0;
        int  wb_cnt = 0;
        bit  second_sent = 0;
        regs_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
        regs_flat[int'(t_rs)*8 +: 8] = t_rsv;
        regs_flat[int'(t_rd)*8 +: 8] = t_rdv;
        r_req_cycles = 0; r_we = -1; r_addr = -1; r_wdata = -1;
        r_wb_cycles = 0; r_wb_val = -1; r_wb_op = -1; r_wb_addr = -1;
        r_done_cycle = -1; r_done_cnt = 0; r_err_cycle = -1; r_err_cnt = 0; r_unstable = 0;
        op = t_op; rd_addr = t_rd; rs_addr = t_rs; imm = t_imm;
        en = 1'b1; mem_ack = 1'b0; wb_ready = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            op = 2'($urandom()); rd_addr = 4'($urandom()); rs_addr = 4'($urandom());
            imm = 8'($urandom());
            if (mem_req) begin
                mem_cnt++;
                r_req_cycles++;
                if (mem_cnt == 1) begin
                    r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
                end else if (r_we != int'(mem_we) || r_addr != int'(mem_addr) ||
                             r_wdata != int'(mem_wdata)) begin
                    r_unstable = 1;
                end
            end
            if (wb_en) begin
                wb_cnt++;
                r_wb_cycles++;
                if (wb_cnt == 1) begin
                    r_wb_val = wb_val; r_wb_op = wb_op; r_wb_addr = wb_reg_addr;
                end else if (r_wb_val != int'(wb_val) || r_wb_op != int'(wb_op) ||
                             r_wb_addr != int'(wb_reg_addr)) begin
                    r_unstable = 1;
                end
            end else begin
                wb_cnt = 0;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cycle < 0) r_done_cycle = c;
            end
            if (err) begin
                r_err_cnt++;
                if (r_err_cycle < 0) r_err_cycle = c;
            end
            mem_ack   = mem_req && (mem_cnt == ack_cyc);
            mem_rdata = mem_ack ? t_rdata : 8'($urandom());
            wb_ready  = wb_en && (wb_cnt >= 2 + extra);
            if (en_in_wb && wb_en && !second_sent) begin
                en = 1'b1; op = OP_ADD; rd_addr = 4'd1; rs_addr = 4'd1;
                second_sent = 1;
            end
        end
        mem_ack = 1'b0;
        wb_ready = 1'b0;
    endtask

    // Transaction-level expectations derived from the instruction alone.
    task automatic check_run(input string name, input logic [1:0] t_op, input logic [3:0] t_rd,
                             input logic [3:0] t_rs, input logic [7:0] t_imm,
                             input logic [7:0] t_rdv, input logic [7:0] t_rsv,
                             input int ack_cyc, input logic [7:0] t_rdata, input int extra);
        bit is_mem  = (t_op == OP_LOD) || (t_op == OP_STR);
        bit timeout = is_mem && (ack_cyc > 15);
        int a = t_rdv;
        int b = (t_rd == t_rs) ? int'(t_rdv) : int'(t_rsv);
        int exp_val;
        int exp_done;
        if (t_op == OP_ADD) exp_val = (a + b) % 256;
        else if (t_op == OP_LOD) exp_val = t_rdata;
        else exp_val = 0;
        if (t_op == OP_ADD) exp_carry = (a + b > 255) ? 1 : 0;
        exp_done = timeout ? -1 : 4 + extra + (is_mem ? ack_cyc : 0);
        chk({name, ".req_cycles"}, r_req_cycles, is_mem ? (timeout ? 15 : ack_cyc) : 0);
        chk({name, ".done_cycle"}, r_done_cycle, exp_done);
        chk({name, ".done_cnt"}, r_done_cnt, timeout ? 0 : 1);
        chk({name, ".err_cycle"}, r_err_cycle, timeout ? 17 : -1);
        chk({name, ".err_cnt"}, r_err_cnt, timeout ? 1 : 0);
        chk({name, ".wb_cycles"}, r_wb_cycles, timeout ? 0 : 3 + extra);
        chk({name, ".stable"}, r_unstable, 0);
        if (!timeout) begin
            chk({name, ".wb_val"}, r_wb_val, exp_val);
            chk({name, ".wb_op"}, r_wb_op, int'(t_op));
            chk({name, ".wb_reg_addr"}, r_wb_addr, int'(t_rd));
        end
        if (is_mem) begin
            chk({name, ".mem_we"}, r_we, (t_op == OP_STR) ? 1 : 0);
            chk({name, ".mem_addr"}, r_addr, int'(t_imm));
            chk({name, ".mem_wdata"}, r_wdata, (t_op == OP_STR) ? a : 0);
        end
`ifdef CARRY_FLAG_EN
        chk({name, ".carry"}, int'(carry), exp_carry);
`endif
        $display("txn %s op=%0d rd=%0d rs=%0d imm=%02h wb_val=%0d done@%0d err@%0d",
                 name, t_op, t_rd, t_rs, t_imm, r_wb_val, r_done_cycle, r_err_cycle);
    endtask

    // Assert reset once a target output is seen, then confirm nothing retires.
    task automatic reset_mid(input string name, input logic [1:0] t_op, input bit wait_wb);
        bit seen = 0;
        int late = 0;
        regs_flat = {$urandom(), $urandom(), $urandom(), $urandom()};
        op = t_op; rd_addr = 4'd3; rs_addr = 4'd6; imm = 8'h44; en = 1'b1;
        mem_ack = 1'b0; wb_ready = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(posedge clk);
            #1;
            en = 1'b0;
            if (wait_wb ? wb_en : mem_req) seen = 1;
        end
        chk({name, ".reached"}, int'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        exp_carry = 0;
        chk({name, ".wb_en"}, int'(wb_en), 0);
        chk({name, ".mem_req"}, int'(mem_req), 0);
        chk({name, ".done"}, int'(done), 0);
        chk({name, ".outs"}, int'({mem_we, mem_addr, mem_wdata, wb_op, wb_reg_addr, wb_val}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done || wb_en || mem_req || err) late++;
        end
        chk({name, ".quiet_after"}, late, 0);
`ifdef CARRY_FLAG_EN
        chk({name, ".carry"}, int'(carry), 0);
`endif
        $display("txn %s reset applied, activity_after=%0d", name, late);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{OP_ADD, 4'd2, 4'd5, 8'h00, 8'h30, 8'h12, 0, 8'h00, 0, 8'h42, 4};
        vecs[1] = '{OP_ADD, 4'd1, 4'd9, 8'h00, 8'hF0, 8'h20, 0, 8'h00, 0, 8'h10, 4};
        vecs[2] = '{OP_NOP, 4'd7, 4'd3, 8'h00, 8'h11, 8'h22, 0, 8'h00, 0, 8'h00, 4};
        vecs[3] = '{OP_LOD, 4'd6, 4'd0, 8'h7A, 8'h01, 8'h02, 3, 8'h5C, 0, 8'h5C, 7};
        vecs[4] = '{OP_STR, 4'd4, 4'd8, 8'h10, 8'h99, 8'h00, 1, 8'hAA, 0, 8'h00, 5};
        vecs[5] = '{OP_LOD, 4'd2, 4'd0, 8'h33, 8'h00, 8'h00, 99, 8'h00, 0, -1, -1};
        vecs[6] = '{OP_LOD, 4'd9, 4'd0, 8'hE1, 8'h00, 8'h00, 15, 8'hC3, 0, 8'hC3, 19};
        vecs[7] = '{OP_ADD, 4'd8, 4'd8, 8'h00, 8'h80, 8'h55, 0, 8'h00, 0, 8'h00, 4};
        vecs[8] = '{OP_ADD, 4'd3, 4'd4, 8'h00, 8'h05, 8'h06, 0, 8'h00, 2, 8'h0B, 6};

        en = 1'b0; op = '0; rd_addr = '0; rs_addr = '0; imm = '0; regs_flat = '0;
        mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctl", int'({mem_req, mem_we, wb_en, done, err}), 0);
        chk("reset.data", int'({mem_addr, mem_wdata, wb_op, wb_reg_addr, wb_val}), 0);
`ifdef CARRY_FLAG_EN
        chk("reset.carry", int'(carry), 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].rdv, vecs[i].rsv,
                vecs[i].ack, vecs[i].rdata, vecs[i].extra, 1'b0);
            chk($sformatf("tbl%0d.done_cycle", i), r_done_cycle, vecs[i].exp_done);
            if (vecs[i].exp_done >= 0) chk($sformatf("tbl%0d.val", i), r_wb_val, vecs[i].exp_val);
            check_run($sformatf("tbl%0d", i), vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm,
                      vecs[i].rdv, vecs[i].rsv, vecs[i].ack, vecs[i].rdata, vecs[i].extra);
        end

        // A second en while in WB must be ignored: single retire, nothing after.
        run(OP_ADD, 4'd10, 4'd11, 8'h00, 8'h21, 8'h43, 0, 8'h00, 1, 1'b1);
        check_run("en_in_wb", OP_ADD, 4'd10, 4'd11, 8'h00, 8'h21, 8'h43, 0, 8'h00, 1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] t_op = 2'($urandom_range(0, 3));
            logic [3:0] t_rd = 4'($urandom());
            logic [3:0] t_rs = 4'($urandom());
            logic [7:0] t_imm = 8'($urandom());
            logic [7:0] t_rdv = 8'($urandom());
            logic [7:0] t_rsv = 8'($urandom());
            int         t_ack = $urandom_range(1, 17);
            logic [7:0] t_rdata = 8'($urandom());
            int         t_extra = $urandom_range(0, 2);
            run(t_op, t_rd, t_rs, t_imm, t_rdv, t_rsv, t_ack, t_rdata, t_extra, 1'b0);
            check_run($sformatf("rnd%0d", i), t_op, t_rd, t_rs, t_imm, t_rdv, t_rsv,
                      t_ack, t_rdata, t_extra);
        end

        reset_mid("rst_in_wb", OP_ADD, 1'b1);
        reset_mid("rst_in_mem", OP_LOD, 1'b0);

        run(OP_ADD, 4'd0, 4'd15, 8'h00, 8'hFF, 8'h01, 0, 8'h00, 0, 1'b0);
        check_run("after_reset", OP_ADD, 4'd0, 4'd15, 8'h00, 8'hFF, 8'h01, 0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
